// File: rtl/core_msg_rx_pkg.sv
// Shared types and field layout for the per-core message receiver.
package core_msg_rx_pkg;

  // Receiver control states
  typedef enum logic [2:0] {
    StIdle,
    StHdrReq,
    StHdrWait,
    StPayReq,
    StPayWait,
    StDrain,
    StDone
  } msg_rx_state_e;

  // Message and header layout
  localparam int unsigned MSG_W        = 32;
  localparam int unsigned PAIR_CNT_W   = 6;
  localparam int unsigned PAIR_CNT_LSB = 0;
  localparam int unsigned HDR_RSVD_LSB = PAIR_CNT_LSB + PAIR_CNT_W;

  // Instruction and r0 entry widths
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned R0_W    = 16;

endpackage

// File: rtl/core_instr_fifo.sv
// Instruction FIFO: two entries pushed per cycle, one popped per cycle.
// A pop in the same cycle frees room that a push may use.
module core_instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data0_i,
  input  logic [WIDTH-1:0]         data1_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  // Room is judged after this cycle's pop has been accounted for
  assign push_ok = push_i & ((count_q - CW'(pop_ok)) <= CW'(DEPTH - 2));

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // Pointer and occupancy next state; pointers wrap modulo DEPTH
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + (push_ok ? AW'(2) : '0);
    count_d  = count_q - CW'(pop_ok) + (push_ok ? CW'(2) : '0);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: both halves written in one cycle
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q]          <= data0_i;
      mem_q[wr_ptr_q + AW'(1)] <= data1_i;
    end
  end

endmodule

// File: rtl/core_msg_rx.sv
// Per-core message receiver: fetches a header and payload pairs from the
// scheduler, buffers instructions for the core and signals completion.
// Optional header reserved-bit checking is enabled by CORE_MSG_RX_HDR_CHECK_EN.
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int unsigned CORE_ID    = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        new_act_core,
  input  logic [15:0]        init_r0_vect,
  input  logic [8*R0_W-1:0]  r0_data,
  input  logic [MSG_W-1:0]   mess_to_core,
  output logic               core_read_f,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [R0_W-1:0]    r0_init_val,
  output logic               r0_init_we,
  input  logic               core_idle,
  output logic               core_busy,
  output logic               done_pulse
`ifdef CORE_MSG_RX_HDR_CHECK_EN
  ,
  output logic               hdr_err
`endif
);

  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned R0_IDX = CORE_ID % 8;

  msg_rx_state_e         state_q, state_d;
  logic [PAIR_CNT_W-1:0] cnt_q, cnt_d;
  logic [R0_W-1:0]       r0_val_q, r0_val_d;
  logic                  r0_we_q, r0_we_d;
  logic                  push;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_room;
  logic                  hdr_bad;

`ifdef CORE_MSG_RX_HDR_CHECK_EN
  logic hdr_err_q, hdr_err_d;
  assign hdr_bad = |mess_to_core[MSG_W-1:HDR_RSVD_LSB];
  assign hdr_err = hdr_err_q;
`else
  assign hdr_bad = 1'b0;
`endif

  core_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data0_i (mess_to_core[INSTR_W-1:0]),
    .data1_i (mess_to_core[MSG_W-1:INSTR_W]),
    .pop_i   (instr_valid & instr_ready),
    .data_o  (instr_out),
    .valid_o (instr_valid),
    .count_o (fifo_count)
  );

  // A payload request needs two free slots so its push can never overflow
  assign fifo_room   = (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign core_busy   = (state_q != StIdle);
  assign r0_init_val = r0_val_q;
  assign r0_init_we  = r0_we_q;

  // Next-state, request and push decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r0_val_d    = r0_val_q;
    r0_we_d     = 1'b0;
    core_read_f = 1'b0;
    push        = 1'b0;
    done_pulse  = 1'b0;
`ifdef CORE_MSG_RX_HDR_CHECK_EN
    hdr_err_d   = hdr_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (new_act_core[CORE_ID]) begin
          state_d = StHdrReq;
          if (init_r0_vect[CORE_ID]) begin
            r0_val_d = r0_data[R0_IDX*R0_W +: R0_W];
            r0_we_d  = 1'b1;
          end
        end
      end
      StHdrReq: begin
        core_read_f = 1'b1;
        state_d     = StHdrWait;
      end
      StHdrWait: begin
        if (hdr_bad) begin
`ifdef CORE_MSG_RX_HDR_CHECK_EN
          hdr_err_d = 1'b1;
`endif
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d   = mess_to_core[PAIR_CNT_LSB +: PAIR_CNT_W];
          state_d = (cnt_d != '0) ? StPayReq : StDrain;
        end
      end
      StPayReq: begin
        if (fifo_room) begin
          core_read_f = 1'b1;
          state_d     = StPayWait;
        end
      end
      StPayWait: begin
        push    = 1'b1;
        cnt_d   = cnt_q - PAIR_CNT_W'(1);
        state_d = (cnt_d != '0) ? StPayReq : StDrain;
      end
      StDrain: begin
        if (!instr_valid && core_idle) state_d = StDone;
      end
      StDone: begin
        done_pulse = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      r0_val_q <= '0;
      r0_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r0_val_q <= r0_val_d;
      r0_we_q  <= r0_we_d;
    end
  end

`ifdef CORE_MSG_RX_HDR_CHECK_EN
  // Sticky header error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_err_q <= 1'b0;
    else        hdr_err_q <= hdr_err_d;
  end
`endif

endmodule
